// File: rtl/lbp_update_queue.sv
// In-order queue of resolved conditional-branch outcomes feeding the local branch
// predictor update port; draining yields to lookups, and overflow is counted rather than stalling.
module lbp_update_queue #(
  parameter int DEPTH      = 4,
  parameter int VLEN       = 64,
  parameter int DROP_CNT_W = 8,
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  resolve_valid_i,
  input  logic                  resolve_is_cond_i,
  input  logic [VLEN-1:0]       resolve_pc_i,
  input  logic                  resolve_taken_i,
  input  logic                  lookup_busy_i,
  output logic                  upd_valid_o,
  input  logic                  upd_ready_i,
  output logic [VLEN-1:0]       upd_pc_o,
  output logic                  upd_taken_o,
  output logic [OCC_W-1:0]      occupancy_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  localparam logic [OCC_W-1:0]      OCC_FULL = OCC_W'(DEPTH);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};

  logic [VLEN-1:0]       mem_pc_q    [DEPTH];
  logic                  mem_taken_q [DEPTH];

  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic empty, full;
  logic push, push_acc, push_drop, pop;

  assign empty = (occ_q == '0);
  assign full  = (occ_q == OCC_FULL);

  // A flushing cycle neither enqueues nor dequeues; its push is silently discarded.
  assign push      = resolve_valid_i & resolve_is_cond_i & ~flush_i;
  assign pop       = upd_valid_o & upd_ready_i;
  assign push_acc  = push & (~full | pop);
  assign push_drop = push & ~push_acc;

  assign upd_valid_o = ~empty & ~lookup_busy_i & ~flush_i;
  assign upd_pc_o    = empty ? '0   : mem_pc_q[rd_ptr_q];
  assign upd_taken_o = empty ? 1'b0 : mem_taken_q[rd_ptr_q];

  assign occupancy_o = occ_q;
  assign full_o      = full;
  assign empty_o     = empty;
  assign drop_cnt_o  = drop_cnt_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    drop_cnt_d = drop_cnt_q;

    if (push_drop && (drop_cnt_q != DROP_MAX)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end

    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      unique case ({push_acc, pop})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: payload storage is not reset; occupancy gates every read, so stale contents are never seen.
  always_ff @(posedge clk_i) begin
    if (push_acc && !rst_i) begin
      mem_pc_q[wr_ptr_q]    <= resolve_pc_i;
      mem_taken_q[wr_ptr_q] <= resolve_taken_i;
    end
  end

endmodule

// File: tb/tb_lbp_update_queue.sv
// Directed bench for lbp_update_queue: stimulus queues expected updates, a monitor
// compares every accepted update against them in order.
module tb_lbp_update_queue;

  localparam int DEPTH = 4;
  localparam int VLEN  = 64;
  localparam int DW    = 8;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             flush_i;
  logic             resolve_valid_i;
  logic             resolve_is_cond_i;
  logic [VLEN-1:0]  resolve_pc_i;
  logic             resolve_taken_i;
  logic             lookup_busy_i;
  logic             upd_valid_o;
  logic             upd_ready_i;
  logic [VLEN-1:0]  upd_pc_o;
  logic             upd_taken_o;
  logic [OCC_W-1:0] occupancy_o;
  logic             full_o;
  logic             empty_o;
  logic [DW-1:0]    drop_cnt_o;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic            taken;
  } upd_t;

  upd_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  lbp_update_queue #(.DEPTH(DEPTH), .VLEN(VLEN), .DROP_CNT_W(DW)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .flush_i           (flush_i),
    .resolve_valid_i   (resolve_valid_i),
    .resolve_is_cond_i (resolve_is_cond_i),
    .resolve_pc_i      (resolve_pc_i),
    .resolve_taken_i   (resolve_taken_i),
    .lookup_busy_i     (lookup_busy_i),
    .upd_valid_o       (upd_valid_o),
    .upd_ready_i       (upd_ready_i),
    .upd_pc_o          (upd_pc_o),
    .upd_taken_o       (upd_taken_o),
    .occupancy_o       (occupancy_o),
    .full_o            (full_o),
    .empty_o           (empty_o),
    .drop_cnt_o        (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: an update is consumed at the next posedge when valid & ready at the negedge.
  always @(negedge clk_i) begin
    if (!rst_i && upd_valid_o && upd_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_update_pc", upd_pc_o, 64'hDEAD);
      end else begin
        upd_t e;
        e = exp_q.pop_front();
        check("drain_pc", upd_pc_o, e.pc);
        check("drain_taken", {63'b0, upd_taken_o}, {63'b0, e.taken});
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one resolve for a single cycle; exp_acc says whether it should be queued.
  task automatic resolve(input logic [VLEN-1:0] pc, input logic taken,
                         input logic is_cond, input logic exp_acc);
    resolve_valid_i   = 1'b1;
    resolve_is_cond_i = is_cond;
    resolve_pc_i      = pc;
    resolve_taken_i   = taken;
    if (exp_acc) exp_q.push_back('{pc: pc, taken: taken});
    cyc();
    resolve_valid_i   = 1'b0;
    resolve_is_cond_i = 1'b0;
    resolve_pc_i      = '0;
    resolve_taken_i   = 1'b0;
  endtask

  task automatic drain(input string name);
    upd_ready_i = 1'b1;
    for (int i = 0; i < 20 && !empty_o; i++) cyc();
    upd_ready_i = 1'b0;
    check(name, {63'b0, empty_o}, 64'd1);
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; lookup_busy_i = 1'b0; upd_ready_i = 1'b0;
    resolve_valid_i = 1'b0; resolve_is_cond_i = 1'b0; resolve_pc_i = '0; resolve_taken_i = 1'b0;

    // 1: reset values, then first-push latency
    cyc(); cyc();
    check("rst_occ",   occupancy_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_full",  full_o, 0);
    check("rst_valid", upd_valid_o, 0);
    check("rst_drop",  drop_cnt_o, 0);
    check("rst_pc",    upd_pc_o, 0);
    check("rst_taken", upd_taken_o, 0);
    rst_i = 1'b0;
    cyc();
    resolve_valid_i = 1'b1; resolve_is_cond_i = 1'b1;
    resolve_pc_i = 64'h8000_0010; resolve_taken_i = 1'b1;
    #1 check("no_bypass_valid", upd_valid_o, 0);
    exp_q.push_back('{pc: 64'h8000_0010, taken: 1'b1});
    cyc();
    resolve_valid_i = 1'b0; resolve_is_cond_i = 1'b0;
    check("t1_valid", upd_valid_o, 1);
    check("t1_pc",    upd_pc_o, 64'h8000_0010);
    check("t1_taken", upd_taken_o, 1);
    drain("t1_drained");

    // 2: fill, overflow drop, in-order drain
    for (int i = 0; i < DEPTH; i++) resolve(64'h1000 + 64'(i) * 4, 1'(i), 1'b1, 1'b1);
    check("t2_full", full_o, 1);
    check("t2_occ",  occupancy_o, 4);
    resolve(64'h1FFF, 1'b1, 1'b1, 1'b0);
    check("t2_drop", drop_cnt_o, 1);
    check("t2_occ_after_drop", occupancy_o, 4);
    check("t2_head_unchanged", upd_pc_o, 64'h1000);
    drain("t2_drained");

    // 3: push and pop in the same cycle at full
    for (int i = 0; i < DEPTH; i++) resolve(64'h2000 + 64'(i) * 4, 1'b0, 1'b1, 1'b1);
    upd_ready_i = 1'b1;
    resolve(64'h2100, 1'b1, 1'b1, 1'b1);
    upd_ready_i = 1'b0;
    check("t3_occ",  occupancy_o, 4);
    check("t3_drop", drop_cnt_o, 1);
    check("t3_head", upd_pc_o, 64'h2004);
    drain("t3_drained");

    // 4: lookups block draining
    resolve(64'h3000, 1'b1, 1'b1, 1'b1);
    resolve(64'h3004, 1'b0, 1'b1, 1'b1);
    lookup_busy_i = 1'b1; upd_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("t4_busy_valid", upd_valid_o, 0);
      cyc();
      check("t4_busy_occ", occupancy_o, 2);
    end
    lookup_busy_i = 1'b0;
    #1 check("t4_release_valid", upd_valid_o, 1);
    cyc();
    check("t4_occ1", occupancy_o, 1);
    cyc();
    check("t4_occ0", occupancy_o, 0);
    upd_ready_i = 1'b0;

    // 5: jumps ignored, flush discards queue and concurrent push
    resolve(64'h4000, 1'b1, 1'b1, 1'b1);
    resolve(64'h4004, 1'b1, 1'b0, 1'b0);
    resolve(64'h4008, 1'b0, 1'b1, 1'b1);
    resolve(64'h400C, 1'b1, 1'b1, 1'b1);
    check("t5_occ_jump_ignored", occupancy_o, 3);
    flush_i = 1'b1; upd_ready_i = 1'b1;
    exp_q.delete();
    #1 check("t5_flush_valid", upd_valid_o, 0);
    resolve(64'h4010, 1'b1, 1'b1, 1'b0);
    flush_i = 1'b0; upd_ready_i = 1'b0;
    check("t5_empty", empty_o, 1);
    check("t5_occ",   occupancy_o, 0);
    check("t5_drop",  drop_cnt_o, 1);
    flush_i = 1'b1; lookup_busy_i = 1'b1;
    cyc();
    flush_i = 1'b0; lookup_busy_i = 1'b0;
    check("t5_idle_occ", occupancy_o, 0);
    resolve(64'h4020, 1'b0, 1'b1, 1'b1);
    check("t5_post_flush_head", upd_pc_o, 64'h4020);
    drain("t5_drained");

    // 6: drop counter saturation; survives flush, cleared by reset
    for (int i = 0; i < DEPTH; i++) resolve(64'h5000 + 64'(i) * 4, 1'b1, 1'b1, 1'b1);
    resolve_valid_i = 1'b1; resolve_is_cond_i = 1'b1; resolve_pc_i = 64'h5FFF;
    for (int i = 0; i < 300; i++) cyc();
    resolve_valid_i = 1'b0; resolve_is_cond_i = 1'b0;
    check("t6_sat", drop_cnt_o, 255);
    flush_i = 1'b1;
    exp_q.delete();
    cyc();
    flush_i = 1'b0;
    check("t6_flush_keeps", drop_cnt_o, 255);
    check("t6_flush_occ",   occupancy_o, 0);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    check("t6_rst_clears", drop_cnt_o, 0);

    check("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
